// File: rtl/fc_core_pkg.sv
// Shared definitions for the fully-connected layer core: data widths,
// accumulator width, phase encoding and the 16-bit saturation helper.
package fc_core_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 44;

  // Layer phases: input features, weights, biases, result drain.
  typedef enum logic [1:0] {
    S_IF  = 2'd0,
    S_W   = 2'd1,
    S_B   = 2'd2,
    S_OUT = 2'd3
  } fc_state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = 44'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_LO = -44'sd32768;

  // Clamp a wide signed value into the signed 16-bit range.
  function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > SAT_HI) begin
      r = 16'h7FFF;
    end else if (v < SAT_LO) begin
      r = 16'h8000;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate for one output neuron. The write-back value
// always reflects the accumulator plus the current product, so the weight
// accepted on the closing cycle is part of the neuron's result.
module fc_mac
  import fc_core_pkg::*;
#(
  parameter int SHIFT = FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              last,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] wb_data
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign sum      = acc + prod_ext;
  assign wb_data  = sat16(sum >>> SHIFT);

  // Accumulate on each accepted weight; the closing weight restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/fc_core.sv
// Fully-connected layer engine. Streams in cin features, cin*cout weights
// (output-major) and optionally cout biases on a single strobed input, then
// drains cout saturated Q8.8 results over a valid/ready output.
//
// Output handshake: dout_valid is high only in S_OUT; a result transfers on
// a rising edge where dout_valid and dout_ready are both high. dout_data is a
// function of the registered output index only, so it stays put while stalled.
// The input strobe is never back-pressured and is ignored in S_OUT.
module fc_core #(
  parameter int DATA_W   = fc_core_pkg::DATA_W,
  parameter int FRAC_W   = fc_core_pkg::FRAC_W,
  parameter int MAX_CIN  = 2048,
  parameter int MAX_COUT = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       cin,
  input  logic [11:0]       cout,
  input  logic              has_bias,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data
);

  import fc_core_pkg::*;

  localparam int CIN_AW  = $clog2(MAX_CIN);
  localparam int COUT_AW = $clog2(MAX_COUT);

  fc_state_t state, state_nxt;
  logic [11:0] i_idx, i_nxt;
  logic [11:0] o_idx, o_nxt;

  logic              x_we, y_we;
  logic [DATA_W-1:0] y_wdata;
  logic [DATA_W-1:0] x_rd, y_rd;
  logic              mac_en, mac_last, mac_clr;
  logic [DATA_W-1:0] mac_wb;

  logic              y_is_zero;
  logic              y_src_zero;
  logic signed [ACC_W-1:0] y_ext, b_ext;
  fc_state_t         after_w, after_if;
  logic              cin_last, cout_last;

  logic [DATA_W-1:0] x_mem [MAX_CIN];
  logic [DATA_W-1:0] y_mem [MAX_COUT];

  // With no input features every sum is zero; the y buffer is not written in
  // that case, so reads of it are replaced by zero until biases land.
  assign y_src_zero = (cin == 12'd0);
  assign y_is_zero  = y_src_zero && !has_bias;

  assign cin_last  = (i_idx == cin - 12'd1);
  assign cout_last = (o_idx == cout - 12'd1);
  assign after_w   = has_bias ? S_B : S_OUT;
  assign after_if  = (cout == 12'd0) ? S_IF : ((cin == 12'd0) ? after_w : S_W);

  assign x_rd = x_mem[i_idx[CIN_AW-1:0]];
  assign y_rd = y_mem[o_idx[COUT_AW-1:0]];

  assign y_ext = y_src_zero ? '0 : {{(ACC_W - DATA_W){y_rd[DATA_W-1]}}, y_rd};
  assign b_ext = {{(ACC_W - DATA_W){din_data[DATA_W-1]}}, din_data};

  assign dout_data = (state == S_OUT && !y_is_zero) ? y_rd : '0;

  fc_mac #(
    .SHIFT(FRAC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .last   (mac_last),
    .a      (x_rd),
    .b      (din_data),
    .wb_data(mac_wb)
  );

  // Input feature buffer: single-port, addressed by the feature index.
  always_ff @(posedge clk) begin
    if (x_we) begin
      x_mem[i_idx[CIN_AW-1:0]] <= din_data;
    end
  end

  // Result buffer: single-port, addressed by the neuron index.
  always_ff @(posedge clk) begin
    if (y_we) begin
      y_mem[o_idx[COUT_AW-1:0]] <= y_wdata;
    end
  end

  // Phase register and index counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IF;
      i_idx <= '0;
      o_idx <= '0;
    end else begin
      state <= state_nxt;
      i_idx <= i_nxt;
      o_idx <= o_nxt;
    end
  end

  // Next-phase, counter and datapath control. A phase closes on the cycle
  // its last word is accepted, so the next strobe already lands in the next
  // phase; empty phases close on entry.
  always_comb begin
    state_nxt  = state;
    i_nxt      = i_idx;
    o_nxt      = o_idx;
    x_we       = 1'b0;
    y_we       = 1'b0;
    y_wdata    = mac_wb;
    mac_en     = 1'b0;
    mac_last   = 1'b0;
    mac_clr    = 1'b0;
    dout_valid = 1'b0;
    case (state)
      S_IF: begin
        if (cin == 12'd0) begin
          state_nxt = after_if;
        end else if (din_valid) begin
          x_we = 1'b1;
          if (cin_last) begin
            i_nxt     = '0;
            state_nxt = after_if;
          end else begin
            i_nxt = i_idx + 12'd1;
          end
        end
      end
      S_W: begin
        if (cin == 12'd0 || cout == 12'd0) begin
          i_nxt     = '0;
          o_nxt     = '0;
          state_nxt = (cout == 12'd0) ? S_IF : after_w;
        end else if (din_valid) begin
          mac_en = 1'b1;
          if (cin_last) begin
            mac_last = 1'b1;
            y_we     = 1'b1;
            y_wdata  = mac_wb;
            i_nxt    = '0;
            if (cout_last) begin
              o_nxt     = '0;
              state_nxt = after_w;
            end else begin
              o_nxt = o_idx + 12'd1;
            end
          end else begin
            i_nxt = i_idx + 12'd1;
          end
        end
      end
      S_B: begin
        if (cout == 12'd0) begin
          o_nxt     = '0;
          state_nxt = S_IF;
        end else if (din_valid) begin
          y_we    = 1'b1;
          y_wdata = sat16(y_ext + b_ext);
          if (cout_last) begin
            o_nxt     = '0;
            state_nxt = S_OUT;
          end else begin
            o_nxt = o_idx + 12'd1;
          end
        end
      end
      S_OUT: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (cout_last) begin
            o_nxt     = '0;
            i_nxt     = '0;
            mac_clr   = 1'b1;
            state_nxt = S_IF;
          end else begin
            o_nxt = o_idx + 12'd1;
          end
        end
      end
      default: begin
        state_nxt = S_IF;
        i_nxt     = '0;
        o_nxt     = '0;
        mac_clr   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fc_core.sv
// Directed bench for fc_core: small layers with hand-computed Q8.8 results.
module tb_fc_core;
  import fc_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [11:0] cin;
  logic [11:0] cout;
  logic        has_bias;
  logic        din_valid;
  logic [15:0] din_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_data;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  fc_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cin       (cin),
    .cout      (cout),
    .has_bias  (has_bias),
    .din_valid (din_valid),
    .din_data  (din_data),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_data (dout_data)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int c_in, input int c_out, input logic bias);
    cin      = 12'(c_in);
    cout     = 12'(c_out);
    has_bias = bias;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_data", 32'(dout_data), 32'd0);
    check("rst_state", 32'(dut.state), 32'(S_IF));
    check("rst_o_idx", 32'(dut.o_idx), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    din_valid = 1'b1;
    din_data  = w;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_data  = '0;
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!dout_valid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("valid_latency", 32'(dout_valid), 32'd1);
  endtask

  // Drain n results against the expected queue, stalling each one.
  task automatic collect(input int n, input int stall);
    logic [15:0] e;
    for (int k = 0; k < n; k++) begin
      wait_valid(2);
      e = exp_q.pop_front();
      dout_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_data", 32'(dout_data), 32'(e));
        @(posedge clk);
        #1;
      end
      dout_ready = 1'b1;
      check("out_data", 32'(dout_data), 32'(e));
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
    end
    check("valid_drop", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    cfg(2, 1, 1'b0);

    // Basic MAC: 1.0*1.0 + 2.0*0.5 = 2.0
    do_reset();
    send_word(16'h0100); send_word(16'h0200);
    send_word(16'h0100); send_word(16'h0080);
    exp_q.push_back(16'h0200);
    collect(1, 0);

    // Same layer with a bias of 0.25
    cfg(2, 1, 1'b1);
    do_reset();
    send_word(16'h0100); send_word(16'h0200);
    send_word(16'h0100); send_word(16'h0080);
    send_word(16'h0040);
    exp_q.push_back(16'h0240);
    collect(1, 0);

    // Sign handling and positive saturation: -1.0*1.0, -1.0*-128.0
    cfg(1, 2, 1'b0);
    do_reset();
    send_word(16'hFF00);
    send_word(16'h0100); send_word(16'h8000);
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'h7FFF);
    collect(2, 0);

    // Backpressure: five stalled cycles per result
    cfg(1, 3, 1'b0);
    do_reset();
    send_word(16'h0100);
    send_word(16'h0001); send_word(16'h0002); send_word(16'h0003);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    collect(3, 5);

    // No input features: all sums are zero
    cfg(0, 2, 1'b0);
    do_reset();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    collect(2, 1);

    // No output neurons: results never offered, core idles in S_IF
    cfg(2, 0, 1'b0);
    do_reset();
    send_word(16'h0100); send_word(16'h0200);
    for (int c = 0; c < 6; c++) begin
      check("cout0_valid", 32'(dout_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    check("cout0_state", 32'(dut.state), 32'(S_IF));
    check("cout0_i_idx", 32'(dut.i_idx), 32'd0);

    // Reset in the middle of the weight phase, then a clean layer
    cfg(2, 1, 1'b0);
    do_reset();
    send_word(16'h0100); send_word(16'h0200);
    send_word(16'h0100);
    check("midw_state", 32'(dut.state), 32'(S_W));
    rst_n = 1'b0;
    #1;
    check("midw_rst_valid", 32'(dout_valid), 32'd0);
    check("midw_rst_state", 32'(dut.state), 32'(S_IF));
    check("midw_rst_i_idx", 32'(dut.i_idx), 32'd0);
    do_reset();
    send_word(16'h0100); send_word(16'h0200);
    send_word(16'h0100); send_word(16'h0080);
    exp_q.push_back(16'h0200);
    collect(1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
